// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and default line timing.
package uart_pkg;

  // Receiver frame-tracking states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int DEFAULT_CLK_FREQ  = 50_000_000;
  localparam int DEFAULT_BAUD_RATE = 115200;

endpackage

// File: rtl/uart_sync_edge.sv
// Two-flop synchronizer for the asynchronous serial line plus a falling-edge
// detector on the synchronized value. Every flop resets to 1 (idle line) so
// releasing reset never produces a false start edge.
module uart_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic rxd,
  output logic rxd_sync,
  output logic fall
);

  logic sync1_reg;
  logic sync2_reg;
  logic prev_reg;

  // Synchronizer chain and previous-value register for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      prev_reg  <= 1'b1;
    end else begin
      sync1_reg <= rxd;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
    end
  end

  assign rxd_sync = sync2_reg;
  assign fall     = prev_reg & ~sync2_reg;

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver. A falling edge on the synchronized line starts a frame;
// every bit is sampled at its middle, counted from the edge-detection cycle.
// A good stop bit loads rx_data and pulses rx_data_valid for one cycle.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = DEFAULT_CLK_FREQ,
  parameter int BAUD_RATE = DEFAULT_BAUD_RATE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic       rx_data_valid,
  output logic [7:0] rx_data
);

  localparam int BIT_CYCLES = CLK_FREQ / BAUD_RATE;
  localparam int HALF_BIT   = BIT_CYCLES / 2;
  localparam int CNT_W      = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

  // The counter holds k-1 in cycle k after the detection cycle, so the start
  // sample lands on HALF_BIT and each later sample one full bit after that.
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);

  logic rxd_sync;
  logic fall;

  rx_state_t        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg,   cnt_next;
  logic [2:0]       bit_reg,   bit_next;
  logic [7:0]       shift_reg, shift_next;
  logic [7:0]       data_reg,  data_next;
  logic             valid_reg, valid_next;

  uart_sync_edge u_sync_edge (
    .clk      (clk),
    .rst      (rst),
    .rxd      (rxd),
    .rxd_sync (rxd_sync),
    .fall     (fall)
  );

  // State, counters, shift register and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      data_reg  <= data_next;
      valid_reg <= valid_next;
    end
  end

  // Next-state logic: edge detection, mid-bit sampling and frame checking.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    data_next  = data_reg;
    valid_next = 1'b0;

    case (state_reg)
      IDLE: begin
        // Edges seen in any other state are ignored by construction.
        if (fall) begin
          state_next = START;
          cnt_next   = '0;
          bit_next   = '0;
        end
      end

      START: begin
        if (cnt_reg == HALF_LAST) begin
          cnt_next   = '0;
          // A high line at mid start bit was only a glitch.
          state_next = rxd_sync ? IDLE : DATA;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      DATA: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next            = '0;
          shift_next[bit_reg] = rxd_sync;
          if (bit_reg == 3'd7) begin
            state_next = STOP;
          end else begin
            bit_next = bit_reg + 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      STOP: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next = '0;
          // Return mid-stop-bit so a back-to-back start edge is not missed.
          state_next = IDLE;
          if (rxd_sync) begin
            data_next  = shift_reg;
            valid_next = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign rx_data       = data_reg;
  assign rx_data_valid = valid_reg;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: back-to-back frames, glitch rejection,
// framing error and mid-frame reset.
module tb_uart_rx_core;
  import uart_pkg::*;

  localparam int BIT = 434;

  logic       clk;
  logic       rst;
  logic       rxd;
  logic       rx_data_valid;
  logic [7:0] rx_data;

  int checks;
  int errors;
  int pulses;
  int double_pulses;
  logic prev_valid;
  longint last_pulse_time;
  longint start_time;

  uart_rx_core dut (
    .clk           (clk),
    .rst           (rst),
    .rxd           (rxd),
    .rx_data_valid (rx_data_valid),
    .rx_data       (rx_data)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Pulse monitor: counts pulses, records when each arrived, flags wide pulses.
  always @(posedge clk) begin
    if (rst) begin
      prev_valid <= 1'b0;
    end else begin
      if (rx_data_valid) begin
        pulses          <= pulses + 1;
        last_pulse_time <= $time;
        $display("pulse %0d: rx_data=%02h at %0t", pulses + 1, rx_data, $time);
      end
      if (rx_data_valid && prev_valid) double_pulses <= double_pulses + 1;
      prev_valid <= rx_data_valid;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic hold_bit(input logic b);
    @(negedge clk);
    rxd = b;
    repeat (BIT - 1) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    @(negedge clk);
    rxd = 1'b0;
    start_time = $time;
    repeat (BIT - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) hold_bit(d[i]);
    hold_bit(stop_bit);
  endtask

  task automatic check_frame(input string tag, input int exp_pulses, input logic [7:0] exp_data);
    longint d;
    check({tag, "_pulses"}, 32'(pulses), 32'(exp_pulses));
    check({tag, "_data"}, {24'd0, rx_data}, {24'd0, exp_data});
    d = (last_pulse_time - start_time) / 20;
    check({tag, "_latency"}, {31'd0, (d >= 4120 && d <= 4135)}, 32'd1);
    $display("frame %s: rx_data=%02h pulses=%0d latency=%0d cycles", tag, rx_data, pulses, d);
  endtask

  initial begin
    checks = 0; errors = 0; pulses = 0; double_pulses = 0;
    last_pulse_time = 0; start_time = 0;
    rxd = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_data", {24'd0, rx_data}, 32'h00);
    check("reset_valid", {31'd0, rx_data_valid}, 32'd0);
    check("reset_state", {30'd0, dut.state_reg}, {30'd0, IDLE});
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // Three back-to-back frames with one stop bit each.
    send_frame(8'h69, 1'b1);
    check_frame("f69", 1, 8'h69);
    send_frame(8'hEF, 1'b1);
    check_frame("fEF", 2, 8'hEF);
    send_frame(8'h81, 1'b1);
    check_frame("f81", 3, 8'h81);
    repeat (BIT) @(negedge clk);
    check("three_pulses", 32'(pulses), 32'd3);

    // 200-cycle low glitch on idle line.
    @(negedge clk);
    rxd = 1'b0;
    repeat (200) @(negedge clk);
    rxd = 1'b1;
    repeat (300) @(negedge clk);
    check("glitch_state", {30'd0, dut.state_reg}, {30'd0, IDLE});
    check("glitch_pulses", 32'(pulses), 32'd3);
    check("glitch_data", {24'd0, rx_data}, 32'h81);
    send_frame(8'h55, 1'b1);
    check_frame("f55", 4, 8'h55);

    // Framing error: stop bit low.
    repeat (BIT) @(negedge clk);
    send_frame(8'hA5, 1'b0);
    check("ferr_pulses", 32'(pulses), 32'd4);
    check("ferr_data", {24'd0, rx_data}, 32'h55);
    hold_bit(1'b1);
    hold_bit(1'b1);
    check("ferr_state", {30'd0, dut.state_reg}, {30'd0, IDLE});
    send_frame(8'h3C, 1'b1);
    check_frame("f3C", 5, 8'h3C);

    // Reset asserted during data bit 4.
    repeat (BIT) @(negedge clk);
    @(negedge clk);
    rxd = 1'b0;
    repeat (BIT - 1) @(negedge clk);
    for (int i = 0; i < 4; i++) hold_bit(1'b0);
    @(negedge clk);
    rxd = 1'b1;
    repeat (200) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_data", {24'd0, rx_data}, 32'h00);
    check("midrst_valid", {31'd0, rx_data_valid}, 32'd0);
    rst = 1'b0;
    repeat (12 * BIT) @(negedge clk);
    check("midrst_state", {30'd0, dut.state_reg}, {30'd0, IDLE});
    check("midrst_pulses", 32'(pulses), 32'd5);
    check("midrst_data_after", {24'd0, rx_data}, 32'h00);
    send_frame(8'hC3, 1'b1);
    check_frame("fC3", 6, 8'hC3);

    repeat (BIT) @(negedge clk);
    check("single_cycle_pulses", 32'(double_pulses), 32'd0);
    check("total_pulses", 32'(pulses), 32'd6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000: system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200: serial bit rate in baud.
REQ-003 Derived constant BIT_CYCLES = CLK_FREQ / BAUD_RATE, integer division (434 at defaults); HALF_BIT = BIT_CYCLES / 2 (217 at defaults).
REQ-004 clk  input  1  single system clock, rising-edge active.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 rxd  input  1  asynchronous serial line, idle high.
REQ-007 rx_data_valid  output  1  one-cycle pulse marking a received byte on rx_data.
REQ-008 rx_data  output  8  last correctly received byte.

Function
REQ-009 Frame format SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1), no parity.
REQ-010 rxd SHALL pass through a 2-flop synchronizer before any use; a falling edge SHALL be detected on the synchronized signal, registered to the previous synchronized value.
REQ-011 The FSM SHALL have states IDLE, START, DATA, STOP.
REQ-012 IDLE -> START on a detected falling edge; the bit counter SHALL clear to 0 in the detection cycle (call it cycle 0).
REQ-013 Sample n (n=0 start, 1..8 data bits 0..7, 9 stop) SHALL be taken from the synchronized line at cycle HALF_BIT + n*BIT_CYCLES after cycle 0.
REQ-014 START: if the start sample is 1 (glitch), the FSM SHALL return to IDLE with no output change; if 0, go to DATA.
REQ-015 DATA: each sample SHALL be shifted into a shift register at bit index n-1 (LSB first); after data bit 7 go to STOP.
REQ-016 STOP: if the stop sample is 1, rx_data SHALL load the shift register and rx_data_valid SHALL be high for exactly the next clock cycle; if 0 (framing error), rx_data SHALL be unchanged, no pulse, and the FSM SHALL return to IDLE.
REQ-017 After the stop sample the FSM SHALL return to IDLE immediately (mid-stop-bit), so back-to-back frames with a one-bit stop are received.
REQ-018 Falling edges on rxd while not in IDLE SHALL be ignored.
REQ-019 rx_data SHALL hold its value between frames; rx_data_valid SHALL be 0 at all times other than REQ-016.
REQ-020 The baud counter SHALL be wide enough for BIT_CYCLES-1 ($clog2 width); it SHALL wrap to 0 at BIT_CYCLES-1 within DATA/STOP.

Reset
REQ-021 While rst is high: FSM in IDLE, counters 0, shift register 0, rx_data = 8'h00, rx_data_valid = 0, both synchronizer flops and edge-detect register = 1 (idle line, so release causes no false start).
REQ-022 Reset asserted mid-frame SHALL abort the frame with no rx_data_valid pulse; reception resumes at the next falling edge after release.

Structure
REQ-023 The FSM state enumeration and the default CLK_FREQ/BAUD_RATE constants SHALL reside in a shared uart_pkg package.
REQ-024 The synchronizer plus falling-edge detector SHALL be one sub-module, uart_sync_edge; all other logic is flat in uart_rx_core.

Verification
REQ-025 Bench: clk 50 MHz (20 ns), rst high for 2 cycles, bits held 434 cycles each, rxd idle high.
REQ-026 Frame bits 0,1,0,0,1,0,1,1,0,1 (start,data LSB first,stop) -> one rx_data_valid pulse, rx_data = 8'h69.
REQ-027 Immediately following frame 0,1,1,1,1,0,1,1,1,1 -> pulse, rx_data = 8'hEF; then 0,1,0,0,0,0,0,0,1,1 -> pulse, rx_data = 8'h81; exactly 3 pulses total, each at about 9.5 bit times after its start edge.
REQ-028 200-cycle low glitch on idle line -> no pulse, FSM back in IDLE, next valid frame 8'h55 received correctly.
REQ-029 Frame 8'hA5 with stop bit driven 0 -> no pulse, rx_data keeps previous value; next frame 8'h3C received correctly.
REQ-030 rst asserted during data bit 4 of a frame -> rx_data = 8'h00, no pulse; frame 8'hC3 after release received correctly.
